tmds_encoder_multi: RTL

//  Registered, NUM_CH-lane TMDS/HDMI symbol encoder for the transmit path.
//  Per lane it produces 8b/10b video symbols with a running disparity counter held inside the block.
//  It also produces control, video/data-island guard band and TERC4 data-island symbols.

---
 rtl/tmds_pkg.sv | 44 ++++
 rtl/tmds_if.sv | 16 +
 rtl/tmds_lane.sv | 118 +++++++++++
 rtl/tmds_encoder_multi.sv | 55 +++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS encoder: mode codes, fixed symbol tables, popcount helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tmds_pkg;

    localparam logic [2:0] MODE_CTRL     = 3'd0;
    localparam logic [2:0] MODE_VIDEO    = 3'd1;
    localparam logic [2:0] MODE_VIDEO_GB = 3'd2;
    localparam logic [2:0] MODE_DATA_GB  = 3'd3;
    localparam logic [2:0] MODE_TERC4    = 3'd4;

    // Indexed by {c1,c0}.
    localparam logic [9:0] CTRL_SYM [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    // Indexed by the 4-bit auxiliary nibble.
    localparam logic [9:0] TERC4_SYM [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    // Indexed by lane role (lane % 3).
    localparam logic [9:0] VGB_SYM [3] = '{
        10'b1011001100, 10'b0100110011, 10'b1011001100
    };

    // Role 0 sends TERC4(aux) in a data guard band; its entry here is never selected.
    localparam logic [9:0] DGB_SYM [3] = '{
        10'b1010011100, 10'b0100110011, 10'b0100110011
    };

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_if.sv
// Bundle of pixel-side inputs and symbol-side outputs of the multi-lane TMDS encoder.
// Latency: n/a (wiring only).
// Backpressure: none; en is the only flow control and freezes the whole pipeline.
interface tmds_if #(parameter int NUM_CH = 3);
    logic                   en;
    logic [2:0]             mode;
    logic [8*NUM_CH-1:0]    d;
    logic [2*NUM_CH-1:0]    c;
    logic [4*NUM_CH-1:0]    aux;
    logic [10*NUM_CH-1:0]   q_out;
    logic                   q_valid;
    logic [5*NUM_CH-1:0]    cnt;

    modport master (output en, mode, d, c, aux, input q_out, q_valid, cnt);
    modport slave  (input en, mode, d, c, aux, output q_out, q_valid, cnt);
endinterface

// File: rtl/tmds_lane.sv
// One TMDS lane: stage 1 transition-minimises the byte, stage 2 balances DC / picks fixed symbols.
// Latency: 2 enabled cycles from inputs to q.
// Backpressure: none; en = 0 holds every register including the running disparity.
// Ports: clk, rst_n; en, mode, d, c, aux in; q (10-bit symbol, bit 0 first), cnt (signed disparity) out.
module tmds_lane
    import tmds_pkg::*;
#(
    parameter int ROLE      = 0,
    parameter bit SWAP_CTRL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [7:0]        d,
    input  logic [1:0]        c,
    input  logic [3:0]        aux,
    output logic [9:0]        q,
    output logic signed [4:0] cnt
);

    localparam logic [1:0] ROLE_IDX = 2'(ROLE % 3);

    // Stage 1 state
    logic [8:0]        q_m_q, q_m_d;
    logic signed [3:0] diff_q, diff_d;
    logic [2:0]        mode_q, mode_d;
    logic [1:0]        c_q, c_d;
    logic [3:0]        aux_q, aux_d;
    // Stage 2 state
    logic [9:0]        q_q, q_d;
    logic signed [4:0] cnt_q, cnt_d;

    logic [3:0]        n1;
    logic              use_xnor;
    logic [8:0]        q_m_new;
    logic signed [4:0] diff2;

    always_comb begin
        n1         = popcount8(d);
        use_xnor   = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q_m_new    = '0;
        q_m_new[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q_m_new[i] = use_xnor ? ~(q_m_new[i-1] ^ d[i]) : (q_m_new[i-1] ^ d[i]);
        end
        q_m_new[8] = ~use_xnor;

        q_m_d  = q_m_q;
        diff_d = diff_q;
        mode_d = mode_q;
        c_d    = c_q;
        aux_d  = aux_q;
        if (en) begin
            q_m_d  = q_m_new;
            // ones minus four = (ones - zeros)/2, range -4..+4
            diff_d = 4'(popcount8(q_m_new[7:0]) - 4'd4);
            // codes 5..7 are folded into CTRL here so stage 2 only sees legal modes
            mode_d = (mode > MODE_TERC4) ? MODE_CTRL : mode;
            c_d    = SWAP_CTRL ? {c[0], c[1]} : c;
            aux_d  = aux;
        end
    end

    always_comb begin
        // 2*diff = ones - zeros of q_m[7:0]
        diff2 = {diff_q[3], diff_q} <<< 1;
        q_d   = q_q;
        cnt_d = cnt_q;
        if (en) begin
            // any non-video symbol restarts the disparity count
            cnt_d = '0;
            case (mode_q)
                MODE_VIDEO: begin
                    if (cnt_q == 5'sd0 || diff_q == 4'sd0) begin
                        q_d   = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
                        cnt_d = q_m_q[8] ? cnt_q + diff2 : cnt_q - diff2;
                    end else if (cnt_q[4] == diff_q[3]) begin
                        // both non-zero with the same sign: invert to pull back toward zero
                        q_d   = {1'b1, q_m_q[8], ~q_m_q[7:0]};
                        cnt_d = cnt_q + {3'b000, q_m_q[8], 1'b0} - diff2;
                    end else begin
                        q_d   = {1'b0, q_m_q[8], q_m_q[7:0]};
                        cnt_d = cnt_q + diff2 - {3'b000, ~q_m_q[8], 1'b0};
                    end
                end
                MODE_VIDEO_GB: q_d = VGB_SYM[ROLE_IDX];
                MODE_DATA_GB:  q_d = (ROLE_IDX == 2'd0) ? TERC4_SYM[aux_q] : DGB_SYM[ROLE_IDX];
                MODE_TERC4:    q_d = TERC4_SYM[aux_q];
                default:       q_d = CTRL_SYM[c_q];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_m_q  <= '0;
            diff_q <= '0;
            mode_q <= MODE_CTRL;
            c_q    <= 2'b00;
            aux_q  <= '0;
            q_q    <= CTRL_SYM[0];
            cnt_q  <= '0;
        end else begin
            q_m_q  <= q_m_d;
            diff_q <= diff_d;
            mode_q <= mode_d;
            c_q    <= c_d;
            aux_q  <= aux_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q   = q_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/tmds_encoder_multi.sv
// NUM_CH-lane TMDS encoder (video, control, guard band, TERC4) feeding the 10:1 serialisers.
// Latency: 2 enabled cycles; q_valid goes high after the second enabled cycle out of reset.
// Backpressure: none; en = 0 freezes q_out, q_valid and cnt.
// Ports: clk, rst_n plain; everything else through the tmds_if slave modport.
module tmds_encoder_multi #(
    parameter int NUM_CH    = 3,
    parameter bit SWAP_CTRL = 1'b0
) (
    input  logic  clk,
    input  logic  rst_n,
    tmds_if.slave bus
);

    logic [10*NUM_CH-1:0] q_all;
    logic [5*NUM_CH-1:0]  cnt_all;
    logic [1:0]           valid_sr_q, valid_sr_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        tmds_lane #(
            .ROLE      (i % 3),
            .SWAP_CTRL (SWAP_CTRL)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bus.en),
            .mode  (bus.mode),
            .d     (bus.d[8*i +: 8]),
            .c     (bus.c[2*i +: 2]),
            .aux   (bus.aux[4*i +: 4]),
            .q     (q_all[10*i +: 10]),
            .cnt   (cnt_all[5*i +: 5])
        );
    end

    // Tracks how many enabled cycles have elapsed since reset, saturating at two.
    always_comb begin
        valid_sr_d = valid_sr_q;
        if (bus.en) begin
            valid_sr_d = {valid_sr_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr_q <= 2'b00;
        end else begin
            valid_sr_q <= valid_sr_d;
        end
    end

    assign bus.q_out   = q_all;
    assign bus.cnt     = cnt_all;
    assign bus.q_valid = valid_sr_q[1];

endmodule
